// File: rtl/rsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rsu_pkg
// Description : Shared types and constants for the RSU block responder.
//               Contents:
//                 - image_t     : 2-bit image index.
//                 - IMG_FACTORY : image selected on a watchdog timeout.
//                 - SR_WIDTH    : width of the serial shift register.
//                 - cfg_state_t : states of the nCONFIG qualification FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package rsu_pkg;

   typedef logic [1:0] image_t;

   localparam image_t IMG_FACTORY = 2'd0;
   localparam int     SR_WIDTH    = 4;

   typedef enum logic [1:0] {
      CFG_IDLE  = 2'd0,
      CFG_HOLD  = 2'd1,
      CFG_APPLY = 2'd2
   } cfg_state_t;

endpackage : rsu_pkg
`default_nettype wire

// File: rtl/rsu_sync.sv
`default_nettype none
// ============================================================================
// Module      : rsu_sync
// Description : N-bit multi-stage synchronizer with a per-bit reset value.
//               Every bit passes through the same number of flops, so
//               signals that were aligned at the input stay aligned at the
//               output.
// Ports       :
//   clk      in   system clock
//   reset    in   synchronous, active-low reset
//   rst_val  in   [WIDTH]  value loaded into every stage during reset
//   d        in   [WIDTH]  asynchronous input bus
//   q        out  [WIDTH]  synchronized bus (last stage)
// Revision    : 1.0 - initial release
// ============================================================================
module rsu_sync #(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] rst_val,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_stage [STAGES];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) begin
            r_stage[i] <= rst_val;
         end
      end else begin
         r_stage[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign q = r_stage[STAGES-1];

endmodule : rsu_sync
`default_nettype wire

// File: rtl/rsu_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : rsu_block_responder
// Description : Emulates the MAX10 dual-image remote-system-upgrade block.
//               A 4-bit serial shift register is clocked by RU_CLK edges
//               detected in the clk domain. Each edge performs a shift,
//               a capture of {cur_image, upd_image}, or an update of
//               upd_image.
//               A qualified RU_nCONFIG pulse switches cur_image to
//               upd_image. A watchdog falls back to the factory image
//               unless RU_nRSTIMER restarts it in time.
// Ports       :
//   clk           in   system clock
//   reset         in   synchronous, active-low reset
//   RU_CLK        in   serial clock from master (asynchronous)
//   RU_DIN        in   serial data, shifted into sr MSB
//   RU_DOUT       out  serial data out, registered sr[0]
//   RU_SHIFTnLD   in   1 = shift, 0 = capture/update
//   RU_CAPTnUPDT  in   with SHIFTnLD=0: 1 = capture, 0 = update
//   RU_nCONFIG    in   active-low reconfigure request
//   RU_nRSTIMER   in   active-low watchdog restart
//   cur_image     out  [2] image currently running
//   upd_image     out  [2] image selected for next reconfig
//   reconfig      out  one-cycle pulse on every image switch
//   wdt_timeout   out  sticky: last switch was caused by the watchdog
// Revision    : 1.0 - initial release
// ============================================================================
module rsu_block_responder
   import rsu_pkg::*;
#(
   parameter int         parSyncStages = 2,
   parameter int         parNcfgMin    = 4,
   parameter int         parWdtCycles  = 1000,
   parameter int         parWdtEnable  = 1,
   parameter logic [1:0] parBootImage  = 2'd1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       RU_CLK,
   input  logic       RU_DIN,
   output logic       RU_DOUT,
   input  logic       RU_SHIFTnLD,
   input  logic       RU_CAPTnUPDT,
   input  logic       RU_nCONFIG,
   input  logic       RU_nRSTIMER,
   output logic [1:0] cur_image,
   output logic [1:0] upd_image,
   output logic       reconfig,
   output logic       wdt_timeout
);

   localparam int c_NCFG_W = $clog2(parNcfgMin + 1);
   localparam int c_WDT_W  = (parWdtCycles > 1) ? $clog2(parWdtCycles) : 1;

   localparam logic [c_NCFG_W-1:0] c_NCFG_MIN = c_NCFG_W'(parNcfgMin);
   localparam logic [c_WDT_W-1:0]  c_WDT_LAST = c_WDT_W'(parWdtCycles - 1);

   // Bus order: {nRSTIMER, nCONFIG, CAPTnUPDT, SHIFTnLD, DIN, CLK}.
   // The active-low requests reset to their inactive (high) level.
   localparam logic [5:0] c_SYNC_RST = 6'b110000;

   // ------------------------------------------------------------------
   // Input synchronization
   // ------------------------------------------------------------------
   logic [5:0] w_ru_raw;
   logic [5:0] w_ru_sync;
   logic       w_clk_s;
   logic       w_din_s;
   logic       w_shift_s;
   logic       w_capt_s;
   logic       w_ncfg_s;
   logic       w_nrst_s;

   assign w_ru_raw = {RU_nRSTIMER, RU_nCONFIG, RU_CAPTnUPDT,
                      RU_SHIFTnLD, RU_DIN, RU_CLK};

   rsu_sync #(
      .WIDTH  (6),
      .STAGES (parSyncStages)
   ) u_sync (
      .clk     (clk),
      .reset   (reset),
      .rst_val (c_SYNC_RST),
      .d       (w_ru_raw),
      .q       (w_ru_sync)
   );

   assign {w_nrst_s, w_ncfg_s, w_capt_s, w_shift_s, w_din_s, w_clk_s} = w_ru_sync;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   cfg_state_t             r_state;
   cfg_state_t             w_state_next;
   logic [c_NCFG_W-1:0]    r_ncfg_cnt;
   logic [c_NCFG_W-1:0]    w_ncfg_cnt_next;
   logic                   w_apply;

   logic                   r_clk_prev;
   logic [SR_WIDTH-1:0]    r_sr;
   logic                   r_dout;
   image_t                 r_cur;
   image_t                 r_upd;
   logic                   r_reconfig;
   logic                   r_wdt_to;
   logic [c_WDT_W-1:0]     r_wdt_cnt;

   logic                   w_edge;
   logic                   w_do_shift;
   logic                   w_do_capt;
   logic                   w_do_updt;
   logic                   w_wdt_run;
   logic                   w_wdt_inc;
   logic                   w_expire;

   // Edges are dropped while a reconfigure request is held low and in the
   // APPLY cycle, where sr is being cleared.
   assign w_edge     = w_clk_s & ~r_clk_prev & w_ncfg_s & (r_state != CFG_APPLY);
   assign w_do_shift = w_edge &  w_shift_s;
   assign w_do_capt  = w_edge & ~w_shift_s &  w_capt_s;
   assign w_do_updt  = w_edge & ~w_shift_s & ~w_capt_s;

   // The restart request beats an expiry in the same cycle.
   assign w_wdt_run = (parWdtEnable != 0) && (r_cur != IMG_FACTORY);
   assign w_expire  = w_wdt_run && w_nrst_s && (r_wdt_cnt == c_WDT_LAST);
   assign w_wdt_inc = w_wdt_run && w_nrst_s && (r_state == CFG_IDLE);

   // ------------------------------------------------------------------
   // nCONFIG qualification FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= CFG_IDLE;
         r_ncfg_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_ncfg_cnt <= w_ncfg_cnt_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_ncfg_cnt_next = r_ncfg_cnt;
      w_apply         = 1'b0;
      case (r_state)
         CFG_IDLE: begin
            if (!w_ncfg_s) begin
               w_state_next    = CFG_HOLD;
               w_ncfg_cnt_next = c_NCFG_W'(1);
            end
         end
         CFG_HOLD: begin
            if (!w_ncfg_s) begin
               // Saturate so long pulses cannot wrap back under the minimum.
               if (r_ncfg_cnt < c_NCFG_MIN) begin
                  w_ncfg_cnt_next = r_ncfg_cnt + c_NCFG_W'(1);
               end
            end else if (r_ncfg_cnt >= c_NCFG_MIN) begin
               w_state_next = CFG_APPLY;
            end else begin
               w_state_next = CFG_IDLE;
            end
         end
         CFG_APPLY: begin
            w_apply      = 1'b1;
            w_state_next = CFG_IDLE;
         end
         default: begin
            w_state_next = CFG_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: shift register, image registers, watchdog
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_clk_prev <= 1'b0;
         r_sr       <= '0;
         r_dout     <= 1'b0;
         r_cur      <= parBootImage;
         r_upd      <= parBootImage;
         r_reconfig <= 1'b0;
         r_wdt_to   <= 1'b0;
         r_wdt_cnt  <= '0;
      end else begin
         r_clk_prev <= w_clk_s;
         r_dout     <= r_sr[0];
         r_reconfig <= w_expire | w_apply;

         if (w_apply) begin
            r_sr <= '0;
         end else if (w_do_shift) begin
            r_sr <= {w_din_s, r_sr[SR_WIDTH-1:1]};
         end else if (w_do_capt) begin
            r_sr <= {r_cur, r_upd};
         end

         // Watchdog expiry has priority over a simultaneous APPLY.
         if (w_expire) begin
            r_cur     <= IMG_FACTORY;
            r_upd     <= IMG_FACTORY;
            r_wdt_to  <= 1'b1;
            r_wdt_cnt <= '0;
         end else if (w_apply) begin
            r_cur     <= r_upd;
            r_wdt_to  <= 1'b0;
            r_wdt_cnt <= '0;
         end else begin
            if (w_do_updt) begin
               r_upd <= r_sr[1:0];
            end
            if (!w_nrst_s) begin
               r_wdt_cnt <= '0;
            end else if (w_wdt_inc) begin
               r_wdt_cnt <= r_wdt_cnt + c_WDT_W'(1);
            end
         end
      end
   end

   assign RU_DOUT     = r_dout;
   assign cur_image   = r_cur;
   assign upd_image   = r_upd;
   assign reconfig    = r_reconfig;
   assign wdt_timeout = r_wdt_to;

endmodule : rsu_block_responder
`default_nettype wire

// File: tb/tb_rsu_block_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsu_block_responder
// Description : Directed self-checking bench for rsu_block_responder with a
//               short (50-cycle) watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsu_block_responder;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       RU_CLK = 1'b0;
   logic       RU_DIN = 1'b0;
   logic       RU_DOUT;
   logic       RU_SHIFTnLD = 1'b0;
   logic       RU_CAPTnUPDT = 1'b0;
   logic       RU_nCONFIG = 1'b1;
   logic       RU_nRSTIMER = 1'b0;
   logic [1:0] cur_image;
   logic [1:0] upd_image;
   logic       reconfig;
   logic       wdt_timeout;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rsu_block_responder #(
      .parSyncStages (2),
      .parNcfgMin    (4),
      .parWdtCycles  (50),
      .parWdtEnable  (1),
      .parBootImage  (2'd1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .RU_CLK       (RU_CLK),
      .RU_DIN       (RU_DIN),
      .RU_DOUT      (RU_DOUT),
      .RU_SHIFTnLD  (RU_SHIFTnLD),
      .RU_CAPTnUPDT (RU_CAPTnUPDT),
      .RU_nCONFIG   (RU_nCONFIG),
      .RU_nRSTIMER  (RU_nRSTIMER),
      .cur_image    (cur_image),
      .upd_image    (upd_image),
      .reconfig     (reconfig),
      .wdt_timeout  (wdt_timeout)
   );

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One RU_CLK pulse with the given mode/data, held around the edge.
   task automatic ru_edge(input logic din, input logic sh, input logic cu);
      RU_DIN       = din;
      RU_SHIFTnLD  = sh;
      RU_CAPTnUPDT = cu;
      tick(2);
      RU_CLK = 1'b1;
      tick(6);
      RU_CLK = 1'b0;
      tick(3);
   endtask

   task automatic ncfg_pulse(input int low, output int pulses);
      RU_nCONFIG = 1'b0;
      tick(low);
      RU_nCONFIG = 1'b1;
      pulses = 0;
      repeat (12) begin
         tick(1);
         if (reconfig) pulses++;
      end
   endtask

   initial begin
      int pulses;
      int cycles;

      // Reset state
      reset = 1'b0;
      tick(3);
      check("rst_cur", 8'(cur_image), 8'd1);
      check("rst_upd", 8'(upd_image), 8'd1);
      check("rst_dout", 8'(RU_DOUT), 8'd0);
      check("rst_reconfig", 8'(reconfig), 8'd0);
      check("rst_wdt", 8'(wdt_timeout), 8'd0);
      reset = 1'b1;
      tick(2);
      check("rel_cur", 8'(cur_image), 8'd1);
      check("rel_upd", 8'(upd_image), 8'd1);

      // Capture then shift out sr = 4'b0101
      ru_edge(1'b0, 1'b0, 1'b1);
      check("cap_dout", 8'(RU_DOUT), 8'd1);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("sh1_dout", 8'(RU_DOUT), 8'd0);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("sh2_dout", 8'(RU_DOUT), 8'd1);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("sh3_dout", 8'(RU_DOUT), 8'd0);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("sh4_dout", 8'(RU_DOUT), 8'd0);

      // Shift in 1,1,0,0 -> sr = 4'b0011, then update
      ru_edge(1'b1, 1'b1, 1'b0);
      ru_edge(1'b1, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("sr0011_dout", 8'(RU_DOUT), 8'd1);
      ru_edge(1'b0, 1'b0, 1'b0);
      check("upd_upd", 8'(upd_image), 8'd3);
      check("upd_cur", 8'(cur_image), 8'd1);
      check("upd_dout", 8'(RU_DOUT), 8'd1);

      // nCONFIG glitch then qualified request
      ncfg_pulse(2, pulses);
      check("glitch_pulses", 8'(pulses), 8'd0);
      check("glitch_cur", 8'(cur_image), 8'd1);
      ncfg_pulse(6, pulses);
      check("cfg_pulses", 8'(pulses), 8'd1);
      check("cfg_cur", 8'(cur_image), 8'd3);
      check("cfg_upd", 8'(upd_image), 8'd3);
      check("cfg_dout", 8'(RU_DOUT), 8'd0);

      // Watchdog expiry: release nRSTIMER and count cycles to the pulse
      RU_nRSTIMER = 1'b1;
      cycles = 0;
      while (!reconfig && cycles < 200) begin
         tick(1);
         cycles++;
      end
      check("wdt_cycles", 8'(cycles), 8'd52);
      check("wdt_cur", 8'(cur_image), 8'd0);
      check("wdt_upd", 8'(upd_image), 8'd0);
      check("wdt_flag", 8'(wdt_timeout), 8'd1);
      tick(1);
      check("wdt_single", 8'(reconfig), 8'd0);
      pulses = 0;
      repeat (60) begin
         tick(1);
         if (reconfig) pulses++;
      end
      check("wdt_halt_pulses", 8'(pulses), 8'd0);
      check("wdt_sticky", 8'(wdt_timeout), 8'd1);

      // Select image 2 (sr = 4'b0010), reconfigure, then keep restarting
      ru_edge(1'b0, 1'b1, 1'b0);
      ru_edge(1'b1, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b0, 1'b0);
      check("upd2_upd", 8'(upd_image), 8'd2);
      ncfg_pulse(6, pulses);
      check("cfg2_pulses", 8'(pulses), 8'd1);
      check("cfg2_cur", 8'(cur_image), 8'd2);
      check("cfg2_wdt_clr", 8'(wdt_timeout), 8'd0);
      pulses = 0;
      repeat (7) begin
         RU_nRSTIMER = 1'b0;
         tick(1);
         if (reconfig) pulses++;
         RU_nRSTIMER = 1'b1;
         repeat (29) begin
            tick(1);
            if (reconfig) pulses++;
         end
      end
      check("kick_pulses", 8'(pulses), 8'd0);
      check("kick_cur", 8'(cur_image), 8'd2);
      check("kick_wdt", 8'(wdt_timeout), 8'd0);

      // Reset between 2nd and 3rd shift edges
      RU_nRSTIMER = 1'b0;
      ru_edge(1'b0, 1'b0, 1'b1);
      ru_edge(1'b0, 1'b1, 1'b0);
      ru_edge(1'b0, 1'b1, 1'b0);
      reset = 1'b0;
      tick(2);
      reset = 1'b1;
      tick(1);
      check("mid_cur", 8'(cur_image), 8'd1);
      check("mid_upd", 8'(upd_image), 8'd1);
      check("mid_dout", 8'(RU_DOUT), 8'd0);
      check("mid_reconfig", 8'(reconfig), 8'd0);
      ru_edge(1'b0, 1'b0, 1'b1);
      check("mid_cap_dout", 8'(RU_DOUT), 8'd1);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("mid_sh1_dout", 8'(RU_DOUT), 8'd0);
      ru_edge(1'b0, 1'b1, 1'b0);
      check("mid_sh2_dout", 8'(RU_DOUT), 8'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_rsu_block_responder
`default_nettype wire

// File: doc/rsu_block_responder.md
Name: rsu_block_responder

Overview:
- Synthesizable responder for the remote-system-upgrade (RSU) serial interface driven by ImageControl; it emulates the MAX10 dual-image RSU block.
- Purpose: the image-control master can be exercised in simulation and on FPGA without the hard IP.
- Holds a 4-bit shift register, an update (next-image) register, a current-image register and a watchdog.
- Handles shift, capture and update on RU_CLK, and image reconfiguration on RU_nCONFIG.

Parameters:
parSyncStages, 2, synchronizer depth applied to all RU_* inputs (2 or 3)
parNcfgMin, 4, minimum clk cycles RU_nCONFIG must stay low to be accepted
parWdtCycles, 1000, watchdog timeout in clk cycles
parWdtEnable, 1, 1 = watchdog active
parBootImage, 2'd1, image loaded into cur_image and upd_image at reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
RU_CLK  in  1  RSU serial clock from master; asynchronous to clk, sampled
RU_DIN  in  1  serial data in, shifted into the MSB
RU_DOUT  out  1  serial data out, = sr[0]
RU_SHIFTnLD  in  1  1 = shift, 0 = capture/update
RU_CAPTnUPDT  in  1  with SHIFTnLD=0: 1 = capture, 0 = update
RU_nCONFIG  in  1  active-low reconfigure request
RU_nRSTIMER  in  1  active-low watchdog restart
cur_image  out  2  image currently "running"
upd_image  out  2  image selected for next reconfig
reconfig  out  1  one-cycle pulse on every image switch
wdt_timeout  out  1  sticky flag: last switch was caused by the watchdog

Behaviour:
- Reset values (reset=0 at a clk edge):
  - sr=4'h0, RU_DOUT=0, reconfig=0, wdt_timeout=0, watchdog counter=0.
  - cur_image=upd_image=parBootImage.
  - Synchronizer flops: RU_CLK, SHIFTnLD and CAPTnUPDT = 0; nCONFIG and nRSTIMER = 1.
- Input sampling:
  - All RU_* inputs pass through parSyncStages flops.
  - An RU_CLK rising edge is detected on the synchronized copy (sync=1, previous=0).
  - DIN, SHIFTnLD and CAPTnUPDT use the same delay, so they stay aligned with the edge.
  - Action occurs parSyncStages+1 clk cycles after the raw edge.
- RU_CLK edge actions, one per detected edge, ignored while nCONFIG (synced) is low:
  - SHIFTnLD=1: sr <= {DIN, sr[3:1]}.
  - SHIFTnLD=0, CAPTnUPDT=1: sr <= {cur_image, upd_image}.
  - SHIFTnLD=0, CAPTnUPDT=0: upd_image <= sr[1:0]; sr unchanged.
- RU_DOUT is registered = sr[0] and updates the cycle after the action.
- nCONFIG states: IDLE, HOLD, APPLY.
  - IDLE -> HOLD on synced nCONFIG low; a low-cycle counter starts at 1.
  - HOLD -> IDLE if nCONFIG returns high with count < parNcfgMin. This is a glitch: no effect.
  - HOLD -> APPLY when nCONFIG returns high with count >= parNcfgMin. The counter saturates.
  - APPLY (one cycle), then IDLE:
    - cur_image <= upd_image
    - sr <= 0
    - watchdog counter <= 0
    - wdt_timeout <= 0
    - reconfig = 1 for this cycle
- Watchdog:
  - Counts when parWdtEnable=1, cur_image != 0 and the FSM is in IDLE.
  - Synced nRSTIMER=0 clears it.
  - On reaching parWdtCycles-1:
    - cur_image <= 2'd0 (factory image)
    - upd_image <= 2'd0
    - wdt_timeout <= 1
    - reconfig pulse
    - counter <= 0
  - Halted while cur_image=0.
- Simultaneous events:
  - Watchdog expiry in the same cycle as APPLY: watchdog wins (cur_image=0, wdt_timeout=1), then FSM returns to IDLE.
  - nRSTIMER low in the expiry cycle: the clear wins, no timeout.
  - RU_CLK edge in the APPLY cycle: ignored.
- Reset mid-shift or mid-HOLD: everything returns to reset values and the partial state is discarded.

Decomposition:
- Package rsu_pkg holds:
  - typedef logic [1:0] image_t
  - constants IMG_FACTORY=2'd0 and SR_WIDTH=4
  - enum cfg_state_t {CFG_IDLE, CFG_HOLD, CFG_APPLY}
- Sub-module rsu_sync: parameterized N-bit multi-stage synchronizer with reset value input. It is instantiated once for the RU_* input bus.

Test Plan:
- Reset release with defaults -> cur_image=1, upd_image=1, RU_DOUT=0, reconfig=0.
- Capture edge, then 4 shift edges with DIN=0 -> RU_DOUT sequence 1,0,1,0 (sr=4'b0101 shifted out LSB first).
- Shift in DIN bits 1,1,0,0 (sr becomes 4'b0011), then update edge -> upd_image=3; cur_image stays 1.
- Assert nCONFIG for 2 cycles -> no change. Then hold it low for 6 cycles and release -> exactly one reconfig pulse, cur_image=3, sr=0.
- parWdtCycles=50, no nRSTIMER -> at cycle 49 after counting starts: cur_image=0, upd_image=0, wdt_timeout=1, reconfig pulse. With nRSTIMER pulsed every 30 cycles -> no timeout over 200 cycles.
- Reset asserted between the 2nd and 3rd shift edges -> all outputs return to reset values; a subsequent capture yields sr=4'b0101.
